md_ctrl: RTL
============

Name: md_ctrl

Overview:
Sequencing controller for the multiply/divide unit used in the E stage of the 5-stage pipeline, together with the HI/LO register pair.
- Accepts one md operation per start pulse from E and holds busy for a fixed latency.
- Commits HI/LO when the operation completes.
- Generates the stall request that freezes F/D while a D-stage md-class instruction (mult/div/mfhi/mflo/mthi/mtlo) would conflict.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
start  in  1  E-stage md instruction valid this cycle
op  in  3  md_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO (others = no-op)
v1  in  32  rs operand, already forwarded
v2  in  32  rt operand, already forwarded
md_use_d  in  1  D-stage instruction is md-class
busy  out  1  multicycle operation in progress
hi  out  32  HI register
lo  out  32  LO register
stall_md  out  1  stall request for F/D; OR-ed into the pipeline Stall

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, busy=0, hi=0, lo=0, operand/result latches=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States are IDLE and RUN; op_q records MUL vs DIV.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - At edge k: latch v1, v2 and op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 in cycles k+1 .. k+N.
- RUN:
  - counter decrements each edge.
  - At the edge where counter==1: write hi/lo from the result, counter→0, go to IDLE.
  - New hi/lo are visible in cycle k+N+1, the same cycle busy returns to 0.
- The result may be computed combinationally from the latched operands or iteratively. Only the commit edge is architecturally visible; hi/lo never change during RUN.
- MTHI/MTLO in IDLE: hi (resp. lo) ← v1 at the next edge; busy stays 0.
- start=1 while busy=1 is ignored entirely, with no state change. The pipeline's stall_md prevents this case.
- Any start in the same cycle as reset=0 is ignored.
- Arithmetic:
  - MULT: signed 32x32→64 product; hi=[63:32], lo=[31:0].
  - MULTU: the unsigned equivalent.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (v2==0): operation runs its full busy period, but hi/lo are left unchanged at commit.
- stall_md = md_use_d & (start | busy). Purely combinational, with no registered delay.
  - This covers mfhi/mflo reading stale values and back-to-back md operations.
  - mfhi/mflo themselves read hi/lo in E.
- Boundary case: start in IDLE on the cycle after a commit is legal; no bubble is required.
- No flush input: the pipeline has no exceptions, so an issued op always completes unless reset intervenes.

Decomposition:
- Shared package md_pkg:
  - md_op_t enum (3-bit)
  - MD_MULT_CYCLES / MD_DIV_CYCLES default constants
  - md_state_t {IDLE, RUN}
- The decoder in the main pipeline imports md_op_t to drive op and md_use_d.
- One sub-module, md_arith: takes the latched operands and op, returns the 64-bit {hi,lo} result and a div-by-zero flag.
- md_ctrl owns the FSM, counter, HI/LO registers and stall output.

Test Plan:
1. MULT, v1=0xFFFFFFFD (-3), v2=7, 1-cycle start → busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB in the cycle busy drops.
2. MULTU, v1=0xFFFFFFFF, v2=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. Then DIV, v1=0xFFFFFFF9 (-7), v2=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. Preload hi=0x11, lo=0x22 via MTHI/MTLO (each visible the next cycle, busy=0). Then DIVU, v1=7, v2=0 → busy 10 cycles; hi=0x11, lo=0x22 unchanged. Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. Hazard:
   - MULT start with md_use_d=1 held → stall_md=1 in the start cycle and all 5 busy cycles, 0 in the cycle after.
   - With md_use_d=0 → stall_md stays 0 throughout.
5. Reset: DIV start, drive reset=0 mid-cycle during busy cycle 4 → busy, hi, lo go to 0 without waiting for a clock edge. After release, no commit occurs and a fresh MULT 3×4 gives lo=12, hi=0.
6. Issue MULT, then hold start=1 with DIV, v2=1 during busy → the DIV is ignored. Commit shows only the MULT result, and busy stays 0 afterwards until a new start.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit and the pipeline decoder.
package md_pkg;

    // Operation code driven by the decoder; codes 6 and 7 are no-ops.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic isMulDiv(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isDivOp(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// E-stage <-> multiply/divide unit signal bundle.
interface md_if;
    import md_pkg::*;

    logic        start;
    md_op_t      op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        md_use_d;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    // Pipeline side: issues operations and reads HI/LO and the stall request.
    modport master (
        output start, op, v1, v2, md_use_d,
        input  busy, hi, lo, stall_md
    );

    // Unit side.
    modport slave (
        input  start, op, v1, v2, md_use_d,
        output busy, hi, lo, stall_md
    );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath on the latched operands.
module md_arith
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        divByZero
);

    logic [63:0] prodSigned;
    logic [63:0] prodUnsigned;
    logic        signedDiv;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [31:0] bSafe;
    logic [31:0] quotMag;
    logic [31:0] remMag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Products are formed at full 64-bit width with explicit extension.
    assign prodSigned   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prodUnsigned = {32'd0, a} * {32'd0, b};

    // Signed division works on magnitudes so that -2^31 / -1 needs no special path.
    assign signedDiv = (op == MD_DIV);
    assign aMag      = (signedDiv && a[31]) ? (32'd0 - a) : a;
    assign bMag      = (signedDiv && b[31]) ? (32'd0 - b) : b;
    assign divByZero = (b == 32'd0);
    assign bSafe     = divByZero ? 32'd1 : bMag;
    assign quotMag   = aMag / bSafe;
    assign remMag    = aMag % bSafe;
    assign quot      = (signedDiv && (a[31] ^ b[31])) ? (32'd0 - quotMag) : quotMag;
    assign rem       = (signedDiv && a[31]) ? (32'd0 - remMag) : remMag;

    // Select the {hi,lo} pair for the latched operation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        result = 64'd0;
        case (op)
            MD_MULT:  result = prodSigned;
            MD_MULTU: result = prodUnsigned;
            MD_DIV,
            MD_DIVU:  result = {rem, quot};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: FSM, latency counter, HI/LO registers and F/D stall.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    md_state_t   state;
    md_state_t   stateNext;
    logic [3:0]  counter;
    logic [3:0]  counterNext;
    logic        launch;
    logic        commit;
    md_op_t      opQ;
    logic [31:0] aQ;
    logic [31:0] bQ;
    logic [31:0] hiQ;
    logic [31:0] loQ;
    logic [63:0] result;
    logic        divByZero;
    logic        idleStart;

    assign idleStart = (state == IDLE) && bus.start;

    md_arith arith (
        .op        (opQ),
        .a         (aQ),
        .b         (bQ),
        .result    (result),
        .divByZero (divByZero)
    );

    // Next-state and counter logic; a start while RUN is ignored.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        launch      = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && isMulDiv(bus.op)) begin
                    launch      = 1'b1;
                    stateNext   = RUN;
                    counterNext = isDivOp(bus.op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end
            end
            RUN: begin
                counterNext = counter - 4'd1;
                if (counter == 4'd1) begin
                    commit    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext   = IDLE;
                counterNext = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
        end
    end

    // Operand latches captured on launch; reset clears them so an aborted op leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opQ <= MD_MULT;
            aQ  <= 32'd0;
            bQ  <= 32'd0;
        end else if (launch) begin
            opQ <= bus.op;
            aQ  <= bus.v1;
            bQ  <= bus.v2;
        end
    end

    // HI/LO: committed result at the end of RUN, or direct moves while IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hiQ <= 32'd0;
            loQ <= 32'd0;
        end else if (commit) begin
            if (!divByZero || !isDivOp(opQ)) begin
                hiQ <= result[63:32];
                loQ <= result[31:0];
            end
        end else if (idleStart && (bus.op == MD_MTHI)) begin
            hiQ <= bus.v1;
        end else if (idleStart && (bus.op == MD_MTLO)) begin
            loQ <= bus.v1;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.hi       = hiQ;
    assign bus.lo       = loQ;
    assign bus.stall_md = bus.md_use_d & (bus.start | bus.busy);

endmodule
